// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: iterative RV32M multiply/divide, radix-2 shift-add and restoring division on magnitudes.
module alu_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [2:0]            func3,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, mc_q, mc_d, result_q, result_d;
  logic          neg_q, neg_d, negr_q, negr_d;
  logic          is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
  logic [W-1:0]  mag_a, mag_b, step_hi, step_lo, quo, rem, fin;
  logic [W:0]    msum, dshift, ddiff;
  logic [2*W-1:0] prod, prod_s;
  always_comb begin
    is_div   = func3[2];
    sgn_a    = is_div ? ~func3[0] : (func3[1:0] == 2'b01 || func3[1:0] == 2'b10);
    sgn_b    = is_div ? ~func3[0] : (func3[1:0] == 2'b01);
    a_neg    = sgn_a & src_a[W-1];
    b_neg    = sgn_b & src_b[W-1];
    mag_a    = a_neg ? -src_a : src_a;
    mag_b    = b_neg ? -src_b : src_b;
    div_zero = is_div && src_b == '0;
    div_ovf  = is_div && !func3[0] && src_a == {1'b1, {(W-1){1'b0}}} && &src_b;
  end
  // hi/lo hold accumulator:multiplier for MUL*, remainder:dividend-becoming-quotient for DIV/REM
  always_comb begin
    msum    = {1'b0, hi_q} + {1'b0, lo_q[0] ? mc_q : {W{1'b0}}};
    dshift  = {hi_q, lo_q[W-1]};
    ddiff   = dshift - {1'b0, mc_q};
    step_hi = op_q[2] ? (ddiff[W] ? dshift[W-1:0] : ddiff[W-1:0]) : msum[W:1];
    step_lo = op_q[2] ? {lo_q[W-2:0], ~ddiff[W]} : {msum[0], lo_q[W-1:1]};
    prod    = {step_hi, step_lo};
    prod_s  = neg_q ? -prod : prod;
    quo     = neg_q ? -step_lo : step_lo;
    rem     = negr_q ? -step_hi : step_hi;
    fin     = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'b00 ? prod_s[W-1:0] : prod_s[2*W-1:W]);
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mc_d     = mc_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    result_d = result_q;
    if (state_q == IDLE && start) begin
      op_d     = func3;
      cnt_d    = '0;
      hi_d     = '0;
      lo_d     = is_div ? mag_a : mag_b;
      mc_d     = is_div ? mag_b : mag_a;
      neg_d    = a_neg ^ b_neg;
      negr_d   = a_neg;
      state_d  = (div_zero || div_ovf) ? DONE : CALC;
      result_d = div_zero ? (func3[1] ? src_a : {W{1'b1}}) :
                 div_ovf  ? (func3[1] ? {W{1'b0}} : src_a) : result_q;
    end else if (state_q == CALC) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(W-1)) begin
        state_d  = DONE;
        result_d = fin;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mc_q     <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else if (en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mc_q     <= mc_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE;
  assign result = result_q;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: directed RV32M vectors; expected results queued at issue, checked when done pulses.
module tb_alu_muldiv_unit;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b1, start = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, done;
  logic [31:0] result;
  int          cyc = 0, checks = 0, errs = 0;
  typedef struct {logic [31:0] res; int at; string name;} exp_t;
  exp_t sbq[$];
  exp_t e;
  alu_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .func3(func3),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sbq.size() == 0) begin
        errs++;
        $display("FAIL unexpected_done: cycle %0d result %h, none expected", cyc, result);
      end else begin
        e = sbq.pop_front();
        if (result !== e.res || cyc != e.at) begin
          errs++;
          $display("FAIL %s: got %h at cycle %0d expected %h at cycle %0d", e.name, result, cyc, e.res, e.at);
        end
      end
    end
  end
  task automatic send(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat);
    exp_t x;
    x.res = exp; x.at = cyc + lat; x.name = name;
    sbq.push_back(x);
    func3 = f; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_busy"}, 32'(busy), 32'd1);
  endtask
  task automatic wait_idle(input string name);
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk); #1;
    end
    if (busy) begin
      checks++; errs++;
      $display("FAIL %s_timeout: busy still 1, required 0", name);
    end
  endtask
  task automatic op(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input int lat);
    send(name, f, a, b, exp, lat);
    wait_idle(name);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;
    op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33);
    op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33);
    op("div_z",  3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    op("rem_z",  3'b110, 32'd5,        32'd0,        32'd5,        1);
    op("divu_z", 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    send("disturb", 3'b101, 32'd1000, 32'd10, 32'd100, 33);
    for (int i = 0; i < 6; i++) begin
      start = 1'b1; func3 = 3'($urandom); src_a = $urandom; src_b = $urandom;
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_idle("disturb");
    send("en_gap", 3'b000, 32'd6, 32'd7, 32'd42, 38);
    repeat (8) begin @(posedge clk); #1; end
    en = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    en = 1'b1;
    wait_idle("en_gap");
    func3 = 3'b100; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33);
    repeat (3) begin @(posedge clk); #1; end
    chk("queue_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
